// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREQ   = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    // Requesters supply word indices; the memory bus expects byte addresses.
    function automatic logic [31:0] wordToByte(input logic [ADDR_W-1:0] wordIdx);
        return {{(32 - ADDR_W - 2){1'b0}}, wordIdx, 2'b00};
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin winner select for two requesters (0 = core, 1 = loader).
module arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic [NREQ-1:0] i_req,
    input  logic            i_lastGnt,
    output logic            o_valid,
    output logic            o_winner
);

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        o_valid  = |i_req;
        o_winner = 1'b0;
        if (i_req == 2'b11) begin
            o_winner = ~i_lastGnt;
        end else if (i_req[1]) begin
            o_winner = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: IDLE -> ACCESS (grant + strobe) -> RESP (ack + read data).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       we,
    input  logic [2*ADDR_W-1:0]   addr,
    input  logic [2*DATA_W-1:0]   wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [DATA_W-1:0]     rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [31:0]           mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy,
    output logic [2*CNT_W-1:0]    grant_cnt
);

    state_t              r_state;
    logic                r_lastGnt;
    logic                r_winner;
    logic                r_we;
    logic [NREQ-1:0]     r_gnt;
    logic [NREQ-1:0]     r_ack;
    logic                r_memRead;
    logic                r_memWrite;
    logic [31:0]         r_memAddr;
    logic [DATA_W-1:0]   r_memWdata;
    logic [CNT_W-1:0]    r_cntCore;
    logic [CNT_W-1:0]    r_cntLoader;

    logic                w_pickValid;
    logic                w_winner;
    logic                w_weSel;
    logic [ADDR_W-1:0]   w_addrSel;
    logic [DATA_W-1:0]   w_wdataSel;

    arb_rr_pick u_pick (
        .i_req     (req),
        .i_lastGnt (r_lastGnt),
        .o_valid   (w_pickValid),
        .o_winner  (w_winner)
    );

    assign w_weSel    = we[w_winner];
    assign w_addrSel  = w_winner ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
    assign w_wdataSel = w_winner ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];

    // The bus-side registers double as the latch for the winning request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_lastGnt   <= 1'b1;
            r_winner    <= 1'b0;
            r_we        <= 1'b0;
            r_gnt       <= '0;
            r_ack       <= '0;
            r_memRead   <= 1'b0;
            r_memWrite  <= 1'b0;
            r_memAddr   <= '0;
            r_memWdata  <= '0;
            r_cntCore   <= '0;
            r_cntLoader <= '0;
        end else begin
            r_gnt      <= '0;
            r_ack      <= '0;
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (w_pickValid) begin
                        r_state    <= ST_ACCESS;
                        r_winner   <= w_winner;
                        r_lastGnt  <= w_winner;
                        r_we       <= w_weSel;
                        r_gnt      <= w_winner ? 2'b10 : 2'b01;
                        r_memRead  <= ~w_weSel;
                        r_memWrite <= w_weSel;
                        r_memAddr  <= wordToByte(w_addrSel);
                        r_memWdata <= w_wdataSel;
                        if (w_winner) begin
                            if (r_cntLoader != {CNT_W{1'b1}}) r_cntLoader <= r_cntLoader + 1'b1;
                        end else begin
                            if (r_cntCore != {CNT_W{1'b1}}) r_cntCore <= r_cntCore + 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    r_state <= ST_RESP;
                    r_ack   <= r_winner ? 2'b10 : 2'b01;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign ack       = r_ack;
    assign mem_read  = r_memRead;
    assign mem_write = r_memWrite;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign busy      = (r_state != ST_IDLE);
    assign grant_cnt = {r_cntLoader, r_cntCore};

    // Memory returns read data in the RESP cycle, so it is passed straight through.
    assign rdata = (r_state == ST_RESP && !r_we) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then random traffic against a pipeline model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [9:0]  addr;
    logic [63:0] wdata;
    logic [31:0] mem_rdata;

    logic [1:0]  gnt, ack;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic        mem_read, mem_write, busy;
    logic [31:0] grant_cnt;

    logic [1:0]  satGnt, satAck;
    logic [31:0] satRdata, satMemAddr, satMemWdata;
    logic        satMemRead, satMemWrite, satBusy;
    logic [7:0]  satGrantCnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .ack(ack), .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .grant_cnt(grant_cnt)
    );

    mem_port_arbiter #(.CNT_W(4)) dutSat (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(satGnt), .ack(satAck), .rdata(satRdata), .mem_read(satMemRead),
        .mem_write(satMemWrite), .mem_addr(satMemAddr), .mem_wdata(satMemWdata),
        .mem_rdata(mem_rdata), .busy(satBusy), .grant_cnt(satGrantCnt)
    );

    // Model: a transaction accepted at one edge is on the bus the next cycle and acknowledged the one after.
    typedef struct {
        bit        v;
        bit        who;
        bit        isWrite;
        bit [4:0]  wordIdx;
        bit [31:0] data;
    } txn_t;

    txn_t        accTxn, rspTxn;
    bit          lastWho = 1'b1;
    int unsigned grants[2];

    function automatic longint unsigned sat(input int unsigned n, input int w);
        longint unsigned maxVal = (64'd1 << w) - 1;
        return (n > maxVal) ? maxVal : longint'(n);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelEdge();
        txn_t nxt;
        bit   w;
        nxt = '{default: 0};
        if (!reset) begin
            accTxn    = '{default: 0};
            rspTxn    = '{default: 0};
            lastWho   = 1'b1;
            grants[0] = 0;
            grants[1] = 0;
        end else begin
            // A new request can be taken whenever the bus is not in its grant cycle.
            if (!accTxn.v && req != 2'b00) begin
                w           = (req == 2'b11) ? !lastWho : req[1];
                nxt.v       = 1'b1;
                nxt.who     = w;
                nxt.isWrite = we[w];
                nxt.wordIdx = addr[w*5 +: 5];
                nxt.data    = wdata[w*32 +: 32];
                lastWho     = w;
                grants[w]++;
            end
            rspTxn = accTxn;
            accTxn = nxt;
        end
    endtask

    task automatic applyStimulus(input logic rstN, input logic [1:0] r, input logic [1:0] w,
                                 input logic [9:0] a, input logic [63:0] d, input logic [31:0] rd);
        reset = rstN;
        req   = r;
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        modelEdge();
        #1 mem_rdata = rd;
        #1;
    endtask

    task automatic checkOutput();
        logic [63:0] expCnt, expSatCnt;
        check("gnt", gnt, accTxn.v ? (2'b01 << accTxn.who) : 2'b00);
        check("mem_read", mem_read, accTxn.v && !accTxn.isWrite);
        check("mem_write", mem_write, accTxn.v && accTxn.isWrite);
        check("mem_addr", mem_addr, accTxn.v ? 64'(accTxn.wordIdx) * 4 : 64'd0);
        check("mem_wdata", mem_wdata, accTxn.v ? accTxn.data : 32'd0);
        check("ack", ack, rspTxn.v ? (2'b01 << rspTxn.who) : 2'b00);
        check("rdata", rdata, (rspTxn.v && !rspTxn.isWrite) ? mem_rdata : 32'd0);
        check("busy", busy, accTxn.v || rspTxn.v);
        expCnt    = (sat(grants[1], 16) << 16) | sat(grants[0], 16);
        expSatCnt = (sat(grants[1], 4) << 4) | sat(grants[0], 4);
        check("grant_cnt", grant_cnt, expCnt);
        check("grant_cnt_w4", satGrantCnt, expSatCnt);
    endtask

    initial begin
        reset = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; mem_rdata = '0;
        accTxn = '{default: 0};
        rspTxn = '{default: 0};
        grants[0] = 0;
        grants[1] = 0;

        applyStimulus(1'b0, 2'b00, 2'b00, 10'd0, 64'd0, 32'd0);
        applyStimulus(1'b0, 2'b11, 2'b11, 10'h3ff, '1, 32'hFFFF_FFFF);
        checkOutput();
        check("reset_gnt", gnt, 2'b00);
        check("reset_cnt", grant_cnt, 32'd0);

        // Single core read of word 3.
        applyStimulus(1'b1, 2'b01, 2'b00, 10'd3, 64'h1111_2222_3333_4444, 32'h0);
        checkOutput();
        check("rd_gnt", gnt, 2'b01);
        check("rd_mem_read", mem_read, 1'b1);
        check("rd_mem_addr", mem_addr, 32'd12);
        applyStimulus(1'b1, 2'b00, 2'b00, 10'd0, 64'd0, 32'hA5A5_0003);
        checkOutput();
        check("rd_ack", ack, 2'b01);
        check("rd_rdata", rdata, 32'hA5A5_0003);
        applyStimulus(1'b1, 2'b00, 2'b00, 10'd0, 64'd0, 32'h0);
        checkOutput();

        // Loader write of word 31.
        applyStimulus(1'b1, 2'b10, 2'b10, {5'd31, 5'd0}, {32'hDEAD_BEEF, 32'h0}, 32'h0);
        checkOutput();
        check("wr_mem_write", mem_write, 1'b1);
        check("wr_mem_addr", mem_addr, 32'd124);
        check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 2'b00, 2'b00, 10'd0, 64'd0, 32'h0);
        checkOutput();
        check("wr_ack", ack, 2'b10);

        // Continuous tie after reset alternates starting with the core.
        applyStimulus(1'b0, 2'b00, 2'b00, 10'd0, 64'd0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 2'b11, 2'b00, 10'd0, 64'd0, $urandom);
            checkOutput();
            if (i % 2 == 0) check("tie_order", gnt, (i % 4 == 0) ? 2'b01 : 2'b10);
        end
        check("tie_cnt", grant_cnt, {16'd2, 16'd2});
        applyStimulus(1'b1, 2'b00, 2'b00, 10'd0, 64'd0, 32'h0);
        checkOutput();

        // Reset during ACCESS aborts the transfer; the next tie goes to the core.
        applyStimulus(1'b1, 2'b10, 2'b00, 10'd0, 64'd0, 32'h0);
        checkOutput();
        applyStimulus(1'b0, 2'b10, 2'b00, 10'd0, 64'd0, 32'h1234_5678);
        checkOutput();
        check("abort_ack", ack, 2'b00);
        check("abort_busy", busy, 1'b0);
        check("abort_mem_read", mem_read, 1'b0);
        applyStimulus(1'b1, 2'b11, 2'b00, 10'd0, 64'd0, 32'h0);
        checkOutput();
        check("abort_tie", gnt, 2'b01);
        applyStimulus(1'b1, 2'b00, 2'b00, 10'd0, 64'd0, 32'h0);
        checkOutput();

        // Twenty back-to-back core grants saturate the narrow counter.
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 2'b01, 2'($urandom), 10'($urandom), {$urandom, $urandom}, $urandom);
            checkOutput();
        end
        check("sat_core", satGrantCnt[3:0], 4'hF);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 39) != 0), 2'($urandom), 2'($urandom),
                          10'($urandom), {$urandom, $urandom}, $urandom);
            checkOutput();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: CNT_W, 16, width of the per-requester grant counters.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous reset, active-low; sampled on the clk rising edge.
REQ-004 req  input  2  request level; bit0 = processor core, bit1 = program loader.
REQ-005 we  input  2  per-requester write enable; 1 = write, 0 = read.
REQ-006 addr  input  10  word index per requester; [4:0] = core, [9:5] = loader.
REQ-007 wdata  input  64  write data per requester; [31:0] = core, [63:32] = loader.
REQ-008 gnt  output  2  one-cycle grant pulse per requester.
REQ-009 ack  output  2  one-cycle completion pulse per requester.
REQ-010 rdata  output  32  read data; valid only in a cycle where ack is high for a read.
REQ-011 mem_read  output  1  memory read strobe.
REQ-012 mem_write  output  1  memory write strobe.
REQ-013 mem_addr  output  32  memory byte address.
REQ-014 mem_wdata  output  32  memory write data.
REQ-015 mem_rdata  input  32  memory read data; valid in the cycle after mem_read.
REQ-016 busy  output  1  high in ACCESS and RESP states.
REQ-017 grant_cnt  output  2*CNT_W  saturating grant counts; [CNT_W-1:0] = core, upper half = loader.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-019 Arbitration SHALL occur only in IDLE and RESP. Any req bit high in such a cycle SHALL cause a transition to ACCESS. Otherwise the next state SHALL be IDLE.
REQ-020 On arbitration, the winner's we, addr and wdata SHALL be latched.
REQ-021 Round-robin: with both req bits high, the requester not granted last SHALL win. With one req bit high, that requester SHALL win.
REQ-022 In ACCESS, gnt[winner] SHALL be 1 for exactly one cycle.
REQ-023 In ACCESS, exactly one of mem_read/mem_write SHALL be 1, selected by the latched we.
REQ-024 In ACCESS, mem_addr SHALL equal {25'b0, latched addr, 2'b00} and mem_wdata SHALL equal the latched wdata.
REQ-025 ACCESS SHALL always be followed by RESP.
REQ-026 In RESP, ack[winner] SHALL be 1 for one cycle. For reads, rdata SHALL equal the value of mem_rdata present in that cycle.
REQ-027 A request SHALL be consumed at grant. A req bit still high in the following RESP cycle SHALL count as a new request.
REQ-028 Latency: req sampled at edge N gives gnt in cycle N+1 and ack in cycle N+2. Back-to-back throughput SHALL be one access per 2 cycles.
REQ-029 Outside ACCESS, mem_read, mem_write, gnt, mem_addr and mem_wdata SHALL be 0.
REQ-030 Outside RESP, ack and rdata SHALL be 0.
REQ-031 grant_cnt[i] SHALL increment on each gnt[i]. It SHALL hold at all-ones and never wrap.
REQ-032 req changes during ACCESS or RESP SHALL NOT alter the transaction in flight.

Reset
REQ-033 With reset=0 at a rising edge, the FSM SHALL go to IDLE and all outputs and both counters SHALL be 0.
REQ-034 Reset SHALL set last-granted to loader, so that the core wins the first tie.
REQ-035 Reset mid-ACCESS or mid-RESP SHALL abort the transaction; no ack SHALL be issued for it.

Structure
REQ-036 Package mem_arb_pkg SHALL hold the state enum and the constants ADDR_W=5, DATA_W=32 and NREQ=2.
REQ-037 One sub-module SHALL exist: arb_rr_pick, a combinational round-robin winner select taking req and last-granted.

Verification
REQ-038 Single core read: req=01, we=0, addr[4:0]=3, mem_rdata=32'hA5A5_0003 -> gnt=01 at N+1 with mem_read=1 and mem_addr=12; ack=01 at N+2 with rdata=32'hA5A5_0003.
REQ-039 Loader write: req=10, we=10, addr[9:5]=31, wdata[63:32]=32'hDEAD_BEEF -> mem_write=1, mem_addr=124 and mem_wdata=32'hDEAD_BEEF in ACCESS; ack=10 next cycle.
REQ-040 Both requesting continuously for 8 cycles after reset -> grants alternate core, loader, core, loader; grant_cnt = 2/2.
REQ-041 Reset asserted in ACCESS -> no ack; all outputs 0 next cycle; subsequent tie goes to core.
REQ-042 Counter preset near saturation (CNT_W=4 build), 20 core grants -> grant_cnt[3:0] holds 4'hF.
